// File: rtl/board_pkg.sv
// Shared constants and types for the board RAM arbiter slice: geometry, cell
// codes, client ids and arbiter states.
package board_pkg;

    localparam int WIDTH  = 32;
    localparam int HEIGHT = 16;
    localparam int XW     = 5;
    localparam int YW     = 4;
    localparam int CW     = 4;

    typedef enum logic [3:0] {
        EMPTY = 4'b0000,
        RIGHT = 4'b0001,
        UP    = 4'b0010,
        LEFT  = 4'b0100,
        DOWN  = 4'b1000,
        APPLE = 4'b1111
    } cell_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_GM   = 2'd2
    } owner_e;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } arb_state_e;

endpackage

// File: rtl/board_clear_seq.sv
// Row-major x/y sweep counter used by the board clear engine.
module board_clear_seq
    import board_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          adv_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o
);

    logic [XW-1:0] x_q;
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_q;
    logic [YW-1:0] y_d;

    // Next sweep position: load restarts at the origin, advance walks row-major.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (load_i) begin
            x_d = '0;
            y_d = '0;
        end else if (adv_i) begin
            if (x_q == XW'(WIDTH - 1)) begin
                x_d = '0;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
                y_d = y_q;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Sweep position register.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == XW'(WIDTH - 1)) && (y_q == YW'(HEIGHT - 1));

endmodule

// File: rtl/board_arbiter.sv
// Shares the single-port board RAM between video scan, game logic and the
// built-in clear sweep; one access per cycle, reads return two cycles after grant.
module board_arbiter
    import board_pkg::*;
#(
    parameter int VID_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vid_req_i,
    input  logic [XW-1:0] vid_x_i,
    input  logic [YW-1:0] vid_y_i,
    output logic          vid_gnt_o,
    output logic          vid_rvalid_o,
    output logic [CW-1:0] vid_rdata_o,
    input  logic          gm_req_i,
    input  logic          gm_we_i,
    input  logic [XW-1:0] gm_x_i,
    input  logic [YW-1:0] gm_y_i,
    input  logic [CW-1:0] gm_wdata_i,
    output logic          gm_gnt_o,
    output logic          gm_rvalid_o,
    output logic [CW-1:0] gm_rdata_o,
    input  logic          clr_start_i,
    output logic          clr_busy_o,
    output logic          clr_done_o,
    output logic [XW-1:0] ram_x_o,
    output logic [YW-1:0] ram_y_o,
    output logic [CW-1:0] ram_in_o,
    output logic          ram_rd_o,
    output logic          ram_wr_o,
    input  logic [CW-1:0] ram_out_i
);

    localparam int SW = $clog2(VID_MAX + 1);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          vid_gnt_s, gm_gnt_s, clr_wr_s, clr_load_s;
    logic [XW-1:0] clr_x_s;
    logic [YW-1:0] clr_y_s;
    logic          clr_last_s;
    owner_e        own_q;
    logic [XW-1:0] ram_x_q;
    logic [YW-1:0] ram_y_q;
    logic [CW-1:0] ram_in_q, vid_rdata_q, gm_rdata_q;
    logic          ram_rd_q, ram_wr_q, vid_rvalid_q, gm_rvalid_q, clr_done_q;

    board_clear_seq u_clear_seq (
        .clk    (clk),
        .rst    (rst),
        .load_i (clr_load_s),
        .adv_i  (clr_wr_s),
        .x_o    (clr_x_s),
        .y_o    (clr_y_s),
        .last_o (clr_last_s)
    );

    // FSM state and starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Next state: clear is entered on start and left after the final cell write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     state_d = clr_start_i ? CLEAR : ARB;
            CLEAR:   state_d = (clr_wr_s && clr_last_s) ? ARB : CLEAR;
            default: state_d = ARB;
        endcase
    end

    // Grant decision; the starve counter only accumulates while the game waits.
    always_comb begin
        vid_gnt_s  = 1'b0;
        gm_gnt_s   = 1'b0;
        clr_wr_s   = 1'b0;
        clr_load_s = 1'b0;
        starve_d   = gm_req_i ? starve_q : '0;
        if (rst) begin
            starve_d = '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (clr_start_i) begin
                        vid_gnt_s  = vid_req_i;
                        clr_load_s = 1'b1;
                    end else if (vid_req_i && !(gm_req_i && (starve_q == SW'(VID_MAX)))) begin
                        vid_gnt_s = 1'b1;
                        starve_d  = gm_req_i ? (starve_q + SW'(1)) : '0;
                    end else if (gm_req_i) begin
                        gm_gnt_s = 1'b1;
                        starve_d = '0;
                    end else begin
                        starve_d = '0;
                    end
                end
                CLEAR: begin
                    if (vid_req_i) begin
                        vid_gnt_s = 1'b1;
                    end else begin
                        clr_wr_s = 1'b1;
                    end
                end
                default: begin
                    starve_d = '0;
                end
            endcase
        end
    end

    // RAM command, owner pipeline and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_x_q      <= '0;
            ram_y_q      <= '0;
            ram_in_q     <= '0;
            ram_rd_q     <= 1'b0;
            ram_wr_q     <= 1'b0;
            own_q        <= OWN_NONE;
            vid_rvalid_q <= 1'b0;
            gm_rvalid_q  <= 1'b0;
            vid_rdata_q  <= '0;
            gm_rdata_q   <= '0;
            clr_done_q   <= 1'b0;
        end else begin
            ram_rd_q   <= vid_gnt_s | (gm_gnt_s & ~gm_we_i);
            ram_wr_q   <= clr_wr_s | (gm_gnt_s & gm_we_i);
            clr_done_q <= clr_wr_s & clr_last_s;
            if (vid_gnt_s) begin
                ram_x_q <= vid_x_i;
                ram_y_q <= vid_y_i;
                own_q   <= OWN_VID;
            end else if (gm_gnt_s) begin
                ram_x_q <= gm_x_i;
                ram_y_q <= gm_y_i;
                if (gm_we_i) begin
                    ram_in_q <= gm_wdata_i;
                    own_q    <= OWN_NONE;
                end else begin
                    own_q    <= OWN_GM;
                end
            end else if (clr_wr_s) begin
                ram_x_q  <= clr_x_s;
                ram_y_q  <= clr_y_s;
                ram_in_q <= EMPTY;
                own_q    <= OWN_NONE;
            end else begin
                own_q    <= OWN_NONE;
            end
            vid_rvalid_q <= (own_q == OWN_VID);
            gm_rvalid_q  <= (own_q == OWN_GM);
            if (own_q == OWN_VID) begin
                vid_rdata_q <= ram_out_i;
            end
            if (own_q == OWN_GM) begin
                gm_rdata_q <= ram_out_i;
            end
        end
    end

    assign vid_gnt_o    = vid_gnt_s;
    assign gm_gnt_o     = gm_gnt_s;
    assign vid_rvalid_o = vid_rvalid_q;
    assign vid_rdata_o  = vid_rdata_q;
    assign gm_rvalid_o  = gm_rvalid_q;
    assign gm_rdata_o   = gm_rdata_q;
    assign clr_busy_o   = (state_q == CLEAR);
    assign clr_done_o   = clr_done_q;
    assign ram_x_o      = ram_x_q;
    assign ram_y_o      = ram_y_q;
    assign ram_in_o     = ram_in_q;
    assign ram_rd_o     = ram_rd_q;
    assign ram_wr_o     = ram_wr_q;

endmodule

// File: tb/tb_board_arbiter.sv
// Self-checking bench for board_arbiter: a behavioural RAM plus a cycle-level
// reference model of the arbitration rules, with read results kept in a queue.
module tb_board_arbiter;

    localparam int VMAX = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       vid_req, gm_req, gm_we, clr_start;
    logic [4:0] vid_x, gm_x, ram_x;
    logic [3:0] vid_y, gm_y, gm_wdata, ram_y, ram_in, ram_out;
    logic       vid_gnt, vid_rvalid, gm_gnt, gm_rvalid, clr_busy, clr_done, ram_rd, ram_wr;
    logic [3:0] vid_rdata, gm_rdata;

    logic [3:0] mem     [0:511];
    logic [3:0] ref_mem [0:511];

    typedef struct {
        int         due;
        bit         vid;
        logic [3:0] d;
    } rd_t;
    rd_t pq[$];

    bit         m_clear, m_done_pend;
    int         m_idx, m_starve, cyc;
    bit         e_vg, e_gg, e_busy, e_done, e_vv, e_gv;
    logic [3:0] e_vd, e_gd;
    int         checks = 0;
    int         errors = 0;

    board_arbiter #(.VID_MAX(VMAX)) dut (
        .clk(clk), .rst(rst),
        .vid_req_i(vid_req), .vid_x_i(vid_x), .vid_y_i(vid_y),
        .vid_gnt_o(vid_gnt), .vid_rvalid_o(vid_rvalid), .vid_rdata_o(vid_rdata),
        .gm_req_i(gm_req), .gm_we_i(gm_we), .gm_x_i(gm_x), .gm_y_i(gm_y),
        .gm_wdata_i(gm_wdata), .gm_gnt_o(gm_gnt), .gm_rvalid_o(gm_rvalid),
        .gm_rdata_o(gm_rdata), .clr_start_i(clr_start), .clr_busy_o(clr_busy),
        .clr_done_o(clr_done), .ram_x_o(ram_x), .ram_y_o(ram_y), .ram_in_o(ram_in),
        .ram_rd_o(ram_rd), .ram_wr_o(ram_wr), .ram_out_i(ram_out)
    );

    always #5 clk = ~clk;

    assign ram_out = mem[{ram_y, ram_x}];
    always @(posedge clk) if (ram_wr) mem[{ram_y, ram_x}] <= ram_in;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model of one cycle; produces expectations for the current cycle.
    task automatic step();
        rd_t r;
        @(negedge clk);
        e_busy = m_clear;
        e_done = m_done_pend;
        m_done_pend = 1'b0;
        e_vv = 1'b0;
        e_gv = 1'b0;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            if (pq[0].vid) begin e_vv = 1'b1; e_vd = pq[0].d; end
            else begin e_gv = 1'b1; e_gd = pq[0].d; end
            void'(pq.pop_front());
        end
        e_vg = 1'b0;
        e_gg = 1'b0;
        if (rst) begin
            m_clear = 1'b0; m_idx = 0; m_starve = 0; pq.delete();
        end else begin
            if (!m_clear) begin
                if (clr_start) begin
                    e_vg = vid_req; m_clear = 1'b1; m_idx = 0;
                end else if (vid_req && !(gm_req && m_starve == VMAX)) begin
                    e_vg = 1'b1;
                    if (gm_req) m_starve++;
                end else if (gm_req) begin
                    e_gg = 1'b1; m_starve = 0;
                end
            end else if (vid_req) begin
                e_vg = 1'b1;
            end else begin
                ref_mem[m_idx] = 4'h0;
                if (m_idx == 511) begin m_clear = 1'b0; m_done_pend = 1'b1; end
                m_idx++;
            end
            if (!gm_req) m_starve = 0;
            if (e_vg) begin
                r.due = cyc + 2; r.vid = 1'b1; r.d = ref_mem[{vid_y, vid_x}];
                pq.push_back(r);
            end
            if (e_gg) begin
                if (gm_we) ref_mem[{gm_y, gm_x}] = gm_wdata;
                else begin
                    r.due = cyc + 2; r.vid = 1'b0; r.d = ref_mem[{gm_y, gm_x}];
                    pq.push_back(r);
                end
            end
        end
        cyc++;
    endtask

    task automatic idle();
        vid_req = 1'b0; gm_req = 1'b0; clr_start = 1'b0; gm_we = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 4; i++) begin step(); tick(); end
    endtask

    task automatic fill_random();
        logic [3:0] v;
        for (int i = 0; i < 512; i++) begin
            v = 4'($urandom_range(15, 1));
            mem[i] = v;
            ref_mem[i] = v;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        vid_x = 5'd0; vid_y = 4'd0; gm_x = 5'd0; gm_y = 4'd0; gm_wdata = 4'd0;
        step(); tick();
        step();
        checks++;
        if (ram_x !== 5'd0 || ram_y !== 4'd0 || ram_in !== 4'd0 || ram_rd !== 1'b0 || ram_wr !== 1'b0) begin
            errors++; $display("FAIL reset_ram got x=%0d y=%0d in=%h rd=%b wr=%b want all 0", ram_x, ram_y, ram_in, ram_rd, ram_wr);
        end
        checks++;
        if (vid_rvalid !== 1'b0 || gm_rvalid !== 1'b0 || vid_rdata !== 4'd0 || gm_rdata !== 4'd0 ||
            clr_busy !== 1'b0 || clr_done !== 1'b0 || vid_gnt !== 1'b0 || gm_gnt !== 1'b0) begin
            errors++; $display("FAIL reset_outs got vv=%b gv=%b vd=%h gd=%h busy=%b done=%b want all 0",
                               vid_rvalid, gm_rvalid, vid_rdata, gm_rdata, clr_busy, clr_done);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_gm_read();
        mem[9*32+3] = 4'b0001; ref_mem[9*32+3] = 4'b0001;
        gm_req = 1'b1; gm_we = 1'b0; gm_x = 5'd3; gm_y = 4'd9;
        step();
        checks++;
        if (gm_gnt !== 1'b1 || vid_gnt !== 1'b0) begin
            errors++; $display("FAIL gm_read_gnt got gm=%b vid=%b want 1 0", gm_gnt, vid_gnt);
        end
        tick(); gm_req = 1'b0;
        step();
        checks++;
        if (ram_rd !== 1'b1 || ram_x !== 5'd3 || ram_y !== 4'd9 || gm_rvalid !== 1'b0 || vid_rvalid !== 1'b0) begin
            errors++; $display("FAIL gm_read_c1 got rd=%b x=%0d y=%0d gv=%b vv=%b want 1 3 9 0 0", ram_rd, ram_x, ram_y, gm_rvalid, vid_rvalid);
        end
        tick();
        step();
        checks++;
        if (gm_rvalid !== 1'b1 || gm_rdata !== 4'b0001 || vid_rvalid !== 1'b0) begin
            errors++; $display("FAIL gm_read_c2 got gv=%b gd=%b vv=%b want 1 0001 0", gm_rvalid, gm_rdata, vid_rvalid);
        end
        tick();
        drain();
    endtask

    task automatic test_starvation();
        vid_req = 1'b1; vid_x = 5'($urandom); vid_y = 4'($urandom);
        gm_req = 1'b1; gm_we = 1'b1; gm_x = 5'd5; gm_y = 4'd5; gm_wdata = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (vid_gnt !== (k != 4) || gm_gnt !== (k == 4)) begin
                errors++; $display("FAIL starve_pattern k=%0d got vid=%b gm=%b want vid=%b gm=%b", k, vid_gnt, gm_gnt, k != 4, k == 4);
            end
            checks++;
            if (vid_rvalid !== e_vv || (e_vv && vid_rdata !== e_vd) || gm_rvalid !== e_gv) begin
                errors++; $display("FAIL starve_rdata k=%0d got vv=%b vd=%h want vv=%b vd=%h", k, vid_rvalid, vid_rdata, e_vv, e_vd);
            end
            tick();
            if (e_gg) gm_req = 1'b0;
            if (e_vg) begin vid_x = 5'($urandom); vid_y = 4'($urandom); end
        end
        drain();
        checks++;
        if (mem[5*32+5] !== 4'b1111) begin
            errors++; $display("FAIL starve_write got %b want 1111", mem[5*32+5]);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step();
            checks++;
            if (vid_gnt !== e_vg || gm_gnt !== e_gg || clr_busy !== e_busy) begin
                errors++; $display("FAIL rand_gnt cyc=%0d got vid=%b gm=%b busy=%b want %b %b %b", cyc, vid_gnt, gm_gnt, clr_busy, e_vg, e_gg, e_busy);
            end
            checks++;
            if (vid_rvalid !== e_vv || gm_rvalid !== e_gv || (e_vv && vid_rdata !== e_vd) || (e_gv && gm_rdata !== e_gd)) begin
                errors++; $display("FAIL rand_rd cyc=%0d got vv=%b vd=%h gv=%b gd=%h want %b %h %b %h",
                                   cyc, vid_rvalid, vid_rdata, gm_rvalid, gm_rdata, e_vv, e_vd, e_gv, e_gd);
            end
            tick();
            if (!vid_req || e_vg) begin
                vid_req = 1'($urandom); vid_x = 5'($urandom); vid_y = 4'($urandom);
            end
            if (!gm_req || e_gg) begin
                gm_req = 1'($urandom); gm_we = 1'($urandom); gm_x = 5'($urandom);
                gm_y = 4'($urandom); gm_wdata = 4'($urandom);
            end
        end
        drain();
    endtask

    task automatic test_clear();
        int busy_cnt = 0, done_cnt = 0, bad = 0;
        bit fin = 1'b0;
        fill_random();
        clr_start = 1'b1;
        step(); tick(); clr_start = 1'b0;
        for (int k = 0; k < 1000 && !fin; k++) begin
            step();
            if (clr_busy) busy_cnt++;
            checks++;
            if (clr_busy !== e_busy || clr_done !== e_done || gm_gnt !== 1'b0) begin
                errors++; $display("FAIL clear_flags cyc=%0d got busy=%b done=%b want %b %b", cyc, clr_busy, clr_done, e_busy, e_done);
            end
            if (clr_done) begin
                done_cnt++;
                checks++;
                if (ram_wr !== 1'b1 || ram_x !== 5'd31 || ram_y !== 4'd15 || clr_busy !== 1'b0) begin
                    errors++; $display("FAIL clear_last got wr=%b x=%0d y=%0d busy=%b want 1 31 15 0", ram_wr, ram_x, ram_y, clr_busy);
                end
                fin = 1'b1;
            end
            tick();
        end
        step(); tick();
        checks++;
        if (!fin || busy_cnt != 512 || done_cnt != 1) begin
            errors++; $display("FAIL clear_len got busy=%0d done=%0d want 512 1", busy_cnt, done_cnt);
        end
        for (int i = 0; i < 512; i++) if (mem[i] !== 4'h0) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL clear_cells got %0d nonzero cells want 0", bad);
        end
        checks++;
        if (clr_busy !== 1'b0) begin
            errors++; $display("FAIL clear_after got busy=%b want 0", clr_busy);
        end
        drain();
    endtask

    task automatic test_clear_video();
        int busy_cnt = 0, stalls = 0, k;
        bit fin = 1'b0, gm_done = 1'b0;
        fill_random();
        clr_start = 1'b1; vid_req = 1'b1; vid_x = 5'($urandom); vid_y = 4'($urandom);
        for (k = 0; k < 3000 && !gm_done; k++) begin
            step();
            if (clr_busy) busy_cnt++;
            if (clr_busy && vid_gnt) stalls++;
            checks++;
            if (vid_gnt !== e_vg || gm_gnt !== e_gg || clr_busy !== e_busy || clr_done !== e_done) begin
                errors++; $display("FAIL clrv_gnt cyc=%0d got vid=%b gm=%b busy=%b done=%b want %b %b %b %b",
                                   cyc, vid_gnt, gm_gnt, clr_busy, clr_done, e_vg, e_gg, e_busy, e_done);
            end
            checks++;
            if (vid_rvalid !== e_vv || gm_rvalid !== e_gv || (e_vv && vid_rdata !== e_vd)) begin
                errors++; $display("FAIL clrv_rd cyc=%0d got vv=%b vd=%h want %b %h", cyc, vid_rvalid, vid_rdata, e_vv, e_vd);
            end
            if (clr_done) fin = 1'b1;
            if (gm_gnt) begin
                gm_done = 1'b1;
                checks++;
                if (!fin || clr_busy !== 1'b0) begin
                    errors++; $display("FAIL clrv_gm_early cyc=%0d got busy=%b want 0 after done", cyc, clr_busy);
                end
            end
            tick();
            clr_start = 1'b0;
            vid_req = (k % 2 == 1) && !fin;
            vid_x = 5'($urandom); vid_y = 4'($urandom);
            if (k == 10) begin
                gm_req = 1'b1; gm_we = 1'b1; gm_x = 5'd7; gm_y = 4'd7; gm_wdata = 4'b0100;
            end
            if (gm_done) gm_req = 1'b0;
        end
        checks++;
        if (!gm_done || busy_cnt != 512 + stalls || stalls == 0) begin
            errors++; $display("FAIL clrv_len got busy=%0d stalls=%0d done=%b want busy=512+stalls", busy_cnt, stalls, gm_done);
        end
        drain();
    endtask

    task automatic test_clear_gm();
        bit fin = 1'b0;
        fill_random();
        clr_start = 1'b1; gm_req = 1'b1; gm_we = 1'b0; gm_x = 5'd7; gm_y = 4'd3;
        step();
        checks++;
        if (gm_gnt !== 1'b0) begin
            errors++; $display("FAIL clrg_start got gm=%b want 0", gm_gnt);
        end
        tick(); clr_start = 1'b0;
        for (int k = 0; k < 1000 && !fin; k++) begin
            step();
            checks++;
            if (gm_gnt !== e_gg || clr_busy !== e_busy || clr_done !== e_done) begin
                errors++; $display("FAIL clrg_step cyc=%0d got gm=%b busy=%b done=%b want %b %b %b", cyc, gm_gnt, clr_busy, clr_done, e_gg, e_busy, e_done);
            end
            if (clr_done) begin
                fin = 1'b1;
                checks++;
                if (gm_gnt !== 1'b1) begin
                    errors++; $display("FAIL clrg_first got gm=%b want 1 in first idle cycle", gm_gnt);
                end
            end
            tick();
            if (fin) gm_req = 1'b0;
        end
        checks++;
        if (!fin) begin
            errors++; $display("FAIL clrg_timeout got no clr_done want one");
        end
        step(); tick(); step();
        checks++;
        if (gm_rvalid !== 1'b1 || gm_rdata !== 4'h0) begin
            errors++; $display("FAIL clrg_rdata got gv=%b gd=%h want 1 0", gm_rvalid, gm_rdata);
        end
        tick();
        drain();
    endtask

    task automatic test_reset_mid_clear();
        logic [3:0] keep;
        fill_random();
        keep = mem[100];
        clr_start = 1'b1;
        step(); tick(); clr_start = 1'b0;
        for (int k = 0; k < 100; k++) begin step(); tick(); end
        vid_req = 1'b1; vid_x = 5'd1; vid_y = 4'd1;
        step(); tick(); vid_req = 1'b0;
        rst = 1'b1;
        step(); tick(); rst = 1'b0;
        step();
        checks++;
        if (clr_busy !== 1'b0 || ram_wr !== 1'b0 || clr_done !== 1'b0 || vid_rvalid !== 1'b0) begin
            errors++; $display("FAIL rstclr_state got busy=%b wr=%b done=%b vv=%b want 0 0 0 0", clr_busy, ram_wr, clr_done, vid_rvalid);
        end
        tick();
        checks++;
        if (mem[100] !== keep || mem[99] !== 4'h0) begin
            errors++; $display("FAIL rstclr_cells got c100=%h c99=%h want %h 0", mem[100], mem[99], keep);
        end
        gm_req = 1'b1; gm_we = 1'b0; gm_x = 5'd4; gm_y = 4'd2;
        step();
        checks++;
        if (gm_gnt !== 1'b1) begin
            errors++; $display("FAIL rstclr_gnt got gm=%b want 1", gm_gnt);
        end
        tick(); gm_req = 1'b0;
        step();
        checks++;
        if (gm_rvalid !== 1'b0) begin
            errors++; $display("FAIL rstclr_early got gv=%b want 0", gm_rvalid);
        end
        tick();
        step();
        checks++;
        if (gm_rvalid !== 1'b1 || gm_rdata !== 4'h0) begin
            errors++; $display("FAIL rstclr_read got gv=%b gd=%h want 1 0", gm_rvalid, gm_rdata);
        end
        tick();
        drain();
    endtask

    initial begin
        cyc = 0; m_clear = 1'b0; m_done_pend = 1'b0; m_idx = 0; m_starve = 0;
        fill_random();
        test_reset();
        test_gm_read();
        test_starvation();
        test_random();
        test_clear();
        test_clear_video();
        test_clear_gm();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
